fc_layer_seq: RTL
=================

// Module: fc_layer_seq
// PURPOSE
//  Sequencer/datapath for one FC layer mapped onto V_CIM_TILES x H_CIM_TILES CIM tiles.
//  Streams the input buffer into the tiles, waits for compute, then reads the output buffers.
//  Reduces partial sums across vertical tiles and requantises them to DATA_SIZE for the next layer.
//  Releases the input buffer as soon as the load phase ends, so the next input can fill during read-out.
// PARAMETERS
//  DATA_SIZE      8    weight/activation width (signed)
//  XBAR_SIZE      512  crossbar dimension
//  V_CIM_TILES    8    vertical tiles; partial sums are summed across them
//  H_CIM_TILES    1    horizontal tiles; independent output lanes
//  NUM_CHANNELS   2    obuf elements read per tile per cycle
//  NUM_ADDR       16   ibuf->CIM write beats per inference (>=1)
//  NUM_ADDR_OBUF  32   obuf read addresses per inference (>=1)
//  OBUF_DATA_SIZE 2*DATA_SIZE+$clog2(XBAR_SIZE)  partial-sum width (signed)
//  SUM_SIZE       OBUF_DATA_SIZE+$clog2(V_CIM_TILES)  reduced-sum width (derived)
// PORTS
//  clk             in   1  clock
//  rst             in   1  async active-high reset
//  i_start         in   1  ibuf full; start an inference (1-cycle pulse)
//  i_shift         in   $clog2(SUM_SIZE)  requant right-shift; sampled with i_start
//  o_ready         out  1  ibuf may be written
//  o_shift_enable  out  1  advance ibuf by one beat
//  o_cim_we        out  1  CIM input write strobe
//  o_cim_addr      out  $clog2(NUM_ADDR)  CIM input address
//  i_cim_ready     in   1  CIM tiles idle / compute done
//  o_obuf_addr     out  $clog2(NUM_ADDR_OBUF)  CIM obuf read address
//  i_cim_data      in   OBUF_DATA_SIZE [H_CIM_TILES][NUM_CHANNELS][V_CIM_TILES]  obuf data, 1 cycle after addr
//  i_next_ready    in   1  next layer may accept data
//  o_next_data     out  DATA_SIZE [H_CIM_TILES][NUM_CHANNELS]  requantised outputs
//  o_next_we       out  1  o_next_data valid
//  o_next_start    out  1  1-cycle pulse after the last o_next_we
// BEHAVIOUR
//  Reset: state IDLE; o_ready=1, all other outputs 0, counters 0, pending-start flag 0.
//  Load FSM: L_IDLE -> L_LOAD on i_start (or pending flag) while i_cim_ready=1.
//   L_LOAD: NUM_ADDR cycles, o_cim_we=o_shift_enable=1, o_cim_addr 0..NUM_ADDR-1; o_ready=0.
//   Last beat -> L_WAIT (o_ready=1 again); i_cim_ready is ignored in the first L_WAIT cycle,
//   then the first cycle with i_cim_ready=1 hands off to the read FSM and returns to L_IDLE.
//  Read FSM: R_IDLE -> R_WAITNX on hand-off; R_WAITNX -> R_READ when i_next_ready=1.
//   R_READ: o_obuf_addr 0..NUM_ADDR_OBUF-1, one per cycle, no stalls once started.
//   Pipeline: addr @t, data @t+1, registered sum/requant @t+2 -> o_next_we=1 @t+2.
//   o_next_start pulses in the cycle after the final o_next_we; then R_IDLE.
//  A new load may begin only when the read FSM is R_IDLE or R_WAITNX (one inference in flight in CIM).
//  i_start while not accepted: set 1-deep pending flag; second i_start while pending is dropped.
//   i_shift is captured at the pulse; a pending start keeps its own captured shift.
//  Arithmetic per (h,ch): sum = signed sum over V of i_cim_data, SUM_SIZE bits (no overflow).
//   q = sum >>> shift (arithmetic; rounds toward -inf); saturate to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
//  i_cim_ready toggling during R_READ has no effect; i_next_ready is sampled only in R_WAITNX.
//  Reset mid-operation: all outputs return to reset values immediately; in-flight data is discarded.
//  Simultaneous i_start and last read beat: the start is accepted (or pended); the read completes normally.
// CONFIGURATION
//  FC_SEQ_RELU_EN defined: after saturation, q<0 -> 0 (ReLU); outputs lie in [0, 2^(DATA_SIZE-1)-1].
//  Not defined: signed saturated output only; negatives pass through.
// TESTING
//  1 Reset: assert rst mid-R_READ -> o_next_we=0, o_ready=1, o_cim_we=0 same cycle; next i_start runs a full inference.
//  2 Load: i_start, NUM_ADDR=16 -> o_cim_we high 16 cycles, addr 0..15, o_ready=0 during the load, 1 after.
//  3 Reduce/requant: all partials=100, V=8, shift=2 -> 800>>>2=200 -> saturates to 127;
//    all=-3, shift=0 -> -24 (ReLU build: 0).
//  4 Handshake: hold i_next_ready=0 for 10 cycles after compute -> no obuf reads;
//    release -> 32 o_next_we beats at latency 2, then 1 o_next_start.
//  5 Overlap: second i_start during read-out -> pended, second load starts once the read FSM is idle/waiting;
//    third i_start while pending -> dropped (exactly 2 o_next_start pulses).
//  6 Ready guard: i_cim_ready held 1 continuously -> load-to-read hand-off no earlier than 2 cycles after the last o_cim_we.

Source files
------------

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: load/compute/read-out sequencer for one FC layer on V x H CIM tiles
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_start, i_shift             start an inference (ibuf full) and its requant shift
//   o_ready                      ibuf may be written (low only while loading the tiles)
//   o_shift_enable, o_cim_we     advance ibuf / write one beat into the tiles
//   o_cim_addr                   tile input address of the current beat
//   i_cim_ready                  tiles idle / compute done
//   o_obuf_addr, i_cim_data      obuf read address; partial sums one cycle later
//   i_next_ready                 next layer may accept data
//   o_next_data, o_next_we       requantised outputs and their strobe
//   o_next_start                 one-cycle pulse after the last o_next_we
// Build option: FC_SEQ_RELU_EN clamps negative results to zero after saturation.
module fc_layer_seq #(
    parameter int DATA_SIZE      = 8,
    parameter int XBAR_SIZE      = 512,
    parameter int V_CIM_TILES    = 8,
    parameter int H_CIM_TILES    = 1,
    parameter int NUM_CHANNELS   = 2,
    parameter int NUM_ADDR       = 16,
    parameter int NUM_ADDR_OBUF  = 32,
    parameter int OBUF_DATA_SIZE = 2 * DATA_SIZE + $clog2(XBAR_SIZE),
    localparam int SUM_SIZE      = OBUF_DATA_SIZE + $clog2(V_CIM_TILES),
    localparam int SW            = $clog2(SUM_SIZE),
    localparam int AW            = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
    localparam int OW            = (NUM_ADDR_OBUF > 1) ? $clog2(NUM_ADDR_OBUF) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic [SW-1:0] i_shift,
    output logic o_ready,
    output logic o_shift_enable,
    output logic o_cim_we,
    output logic [AW-1:0] o_cim_addr,
    input  logic i_cim_ready,
    output logic [OW-1:0] o_obuf_addr,
    input  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][V_CIM_TILES-1:0][OBUF_DATA_SIZE-1:0] i_cim_data,
    input  logic i_next_ready,
    output logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] o_next_data,
    output logic o_next_we,
    output logic o_next_start
);
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_GUARD, L_WAIT} l_state_t;
    typedef enum logic [2:0] {R_IDLE, R_WAITNX, R_READ, R_DRAIN, R_DONE} r_state_t;

    localparam logic signed [SUM_SIZE-1:0] SAT_HI = SUM_SIZE'((1 << (DATA_SIZE - 1)) - 1);
`ifdef FC_SEQ_RELU_EN
    localparam logic signed [SUM_SIZE-1:0] SAT_LO = '0;
`else
    localparam logic signed [SUM_SIZE-1:0] SAT_LO = -SAT_HI - SUM_SIZE'(1);
`endif

    l_state_t r_lst, w_lst_nx;
    r_state_t r_rst_st, w_rst_nx;
    logic [AW-1:0] r_ld_cnt;
    logic [OW-1:0] r_rd_cnt;
    logic r_pend;
    logic [SW-1:0] r_shift_pend, r_shift_load, r_shift_read;
    logic r_v1, r_next_we;
    logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] r_next_data, w_q;
    logic signed [SUM_SIZE-1:0] w_acc, w_shr, w_clip;
    logic w_can, w_go, w_ld_last, w_rd_last, w_handoff;

    // Only one inference may sit in the tiles: a load needs the read side idle or still waiting.
    assign w_can     = (r_lst == L_IDLE) && i_cim_ready && (r_rst_st == R_IDLE || r_rst_st == R_WAITNX);
    assign w_go      = w_can && (i_start || r_pend);
    assign w_ld_last = r_ld_cnt == AW'(NUM_ADDR - 1);
    assign w_rd_last = r_rd_cnt == OW'(NUM_ADDR_OBUF - 1);
    assign w_handoff = (r_lst == L_WAIT) && i_cim_ready && (r_rst_st == R_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lst    <= L_IDLE;
            r_rst_st <= R_IDLE;
        end else begin
            r_lst    <= w_lst_nx;
            r_rst_st <= w_rst_nx;
        end
    end

    // L_GUARD masks i_cim_ready for one cycle: the tiles need a cycle to drop it after the last write.
    always_comb begin
        w_lst_nx       = r_lst;
        w_rst_nx       = r_rst_st;
        o_ready        = r_lst != L_LOAD;
        o_cim_we       = r_lst == L_LOAD;
        o_shift_enable = r_lst == L_LOAD;
        o_next_start   = r_rst_st == R_DONE;
        case (r_lst)
            L_IDLE:  w_lst_nx = w_go ? L_LOAD : L_IDLE;
            L_LOAD:  w_lst_nx = w_ld_last ? L_GUARD : L_LOAD;
            L_GUARD: w_lst_nx = L_WAIT;
            default: w_lst_nx = w_handoff ? L_IDLE : L_WAIT;
        endcase
        case (r_rst_st)
            R_IDLE:   w_rst_nx = w_handoff ? R_WAITNX : R_IDLE;
            R_WAITNX: w_rst_nx = i_next_ready ? R_READ : R_WAITNX;
            R_READ:   w_rst_nx = w_rd_last ? R_DRAIN : R_READ;
            R_DRAIN:  w_rst_nx = r_v1 ? R_DRAIN : R_DONE;
            default:  w_rst_nx = R_IDLE;
        endcase
    end

    // Reduce across vertical tiles, arithmetic shift (floor), then clamp.
    always_comb begin
        w_q    = '0;
        w_acc  = '0;
        w_shr  = '0;
        w_clip = '0;
        for (int h = 0; h < H_CIM_TILES; h++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                w_acc = '0;
                for (int v = 0; v < V_CIM_TILES; v++)
                    w_acc = w_acc + SUM_SIZE'($signed(i_cim_data[h][c][v]));
                w_shr     = w_acc >>> r_shift_read;
                w_clip    = (w_shr > SAT_HI) ? SAT_HI : (w_shr < SAT_LO) ? SAT_LO : w_shr;
                w_q[h][c] = w_clip[DATA_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_pend       <= 1'b0;
            r_shift_pend <= '0;
            r_shift_load <= '0;
            r_shift_read <= '0;
            r_v1         <= 1'b0;
            r_next_we    <= 1'b0;
            r_next_data  <= '0;
        end else begin
            r_ld_cnt  <= (r_lst == L_LOAD && !w_ld_last) ? r_ld_cnt + AW'(1) : '0;
            r_rd_cnt  <= (r_rst_st == R_READ && !w_rd_last) ? r_rd_cnt + OW'(1) : '0;
            r_v1      <= r_rst_st == R_READ;
            r_next_we <= r_v1;
            if (r_v1)
                r_next_data <= w_q;
            // A start that cannot be taken now fills the single pending slot; when the pending
            // start is consumed, a coincident new pulse takes its place.
            if (i_start && (r_pend ? w_can : !w_can)) begin
                r_pend       <= 1'b1;
                r_shift_pend <= i_shift;
            end else if (w_can)
                r_pend <= 1'b0;
            if (w_go)
                r_shift_load <= r_pend ? r_shift_pend : i_shift;
            if (w_handoff)
                r_shift_read <= r_shift_load;
        end
    end

    assign o_cim_addr  = r_ld_cnt;
    assign o_obuf_addr = r_rd_cnt;
    assign o_next_we   = r_next_we;
    assign o_next_data = r_next_data;
endmodule
